// File: rtl/music_seq_ctrl.sv
// music_seq_ctrl: song sequencer that walks the note ROM, times each
// note slot (FETCH, PLAY, GAP, ADVANCE) and drives note/gate to the tone path.
// Ports: clk, rst (async, high); start/stop pulses, pause/loop_en levels;
//   tempo_load/tempo_in set the slot length; rom_addr/rom_note talk to the
//   note ROM; note/gate feed the tone datapath; busy/beat/song_done status.
module music_seq_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int NOTE_W        = 8,
  parameter int TEMPO_W       = 24,
  parameter int TEMPO_DEFAULT = 4194304,
  parameter int GAP_CYCLES    = 65536,
  parameter int LAST_ADDR     = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               loop_en,
  input  logic               tempo_load,
  input  logic [TEMPO_W-1:0] tempo_in,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [NOTE_W-1:0]  rom_note,
  output logic [NOTE_W-1:0]  note,
  output logic               gate,
  output logic               busy,
  output logic               beat,
  output logic               song_done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, PLAY, GAP, ADVANCE, PAUSED
  } state_t;

  localparam logic [TEMPO_W-1:0] T_DEF = TEMPO_W'(TEMPO_DEFAULT);
  localparam logic [TEMPO_W-1:0] T_GAP = TEMPO_W'(GAP_CYCLES);
  localparam logic [TEMPO_W-1:0] T_GM1 = TEMPO_W'(GAP_CYCLES - 1);
  localparam logic [TEMPO_W-1:0] T_ONE = TEMPO_W'(1);
  localparam logic [ADDR_W-1:0]  A_LAST = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0]  A_ONE  = ADDR_W'(1);

  state_t              state, state_d;
  state_t              ret, ret_d;
  state_t              seq_s;
  logic [TEMPO_W-1:0]  cnt, cnt_d, seq_c;
  logic [TEMPO_W-1:0]  plen_m1, plen_d, plen_new;
  logic [TEMPO_W-1:0]  tempo_reg;
  logic [ADDR_W-1:0]   addr_d;
  logic [NOTE_W-1:0]   note_d;
  logic                beat_d, done_d;

  // Play length minus one, taken from tempo_reg only at PLAY entry.
  assign plen_new = (tempo_reg > T_GAP) ? (tempo_reg - T_GAP - T_ONE)
                                        : '0;

  assign gate = (state == PLAY) && (note != '0);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ret       <= IDLE;
      cnt       <= '0;
      plen_m1   <= '0;
      tempo_reg <= T_DEF;
      rom_addr  <= '0;
      note      <= '0;
      beat      <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_d;
      ret       <= ret_d;
      cnt       <= cnt_d;
      plen_m1   <= plen_d;
      rom_addr  <= addr_d;
      note      <= note_d;
      beat      <= beat_d;
      song_done <= done_d;
      if (tempo_load)
        tempo_reg <= (tempo_in == '0) ? T_ONE : tempo_in;
    end
  end

  always_comb begin
    seq_s = state;
    seq_c = cnt + T_ONE;
    case (state)
      FETCH:
        if (cnt == T_ONE) begin
          seq_s = PLAY;
          seq_c = '0;
        end
      PLAY:
        if (cnt == plen_m1) begin
          seq_s = (GAP_CYCLES == 0) ? ADVANCE : GAP;
          seq_c = '0;
        end
      GAP:
        if (cnt == T_GM1) begin
          seq_s = ADVANCE;
          seq_c = '0;
        end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    ret_d   = ret;
    cnt_d   = cnt;
    plen_d  = plen_m1;
    addr_d  = rom_addr;
    note_d  = note;
    beat_d  = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      addr_d  = '0;
      note_d  = '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            cnt_d   = '0;
            addr_d  = '0;
            ret_d   = FETCH;
            state_d = pause ? PAUSED : FETCH;
          end
        FETCH:
          if (pause) begin
            // ROM data is re-awaited in full after a pause.
            state_d = PAUSED;
            ret_d   = FETCH;
            cnt_d   = '0;
          end else begin
            state_d = seq_s;
            cnt_d   = seq_c;
            if (seq_s == PLAY) begin
              note_d = rom_note;
              beat_d = 1'b1;
              plen_d = plen_new;
            end
          end
        PLAY, GAP: begin
          // The pausing cycle still counts; resume where it would go.
          cnt_d = seq_c;
          if (pause) begin
            state_d = PAUSED;
            ret_d   = seq_s;
          end else begin
            state_d = seq_s;
          end
        end
        ADVANCE: begin
          cnt_d = '0;
          if (rom_addr < A_LAST) begin
            addr_d  = rom_addr + A_ONE;
            state_d = FETCH;
          end else if (loop_en) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            addr_d  = '0;
            note_d  = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        PAUSED:
          if (!pause)
            state_d = ret;
        default:
          state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// tb_music_seq_ctrl: randomized scenario bench for music_seq_ctrl with a
// slot-level timing model and a registered 4-entry song ROM.
module tb_music_seq_ctrl;
  localparam int AW   = 8;
  localparam int NW   = 8;
  localparam int TW   = 24;
  localparam int TDEF = 16;
  localparam int GAPC = 4;
  localparam int LAST = 3;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, loop_en, tempo_load;
  logic [TW-1:0] tempo_in;
  logic [AW-1:0] rom_addr;
  logic [NW-1:0] rom_note = '0;
  logic [NW-1:0] note;
  logic          gate, busy, beat, song_done;

  int checks = 0;
  int failures = 0;
  int tempo_m = TDEF;

  music_seq_ctrl #(
    .ADDR_W(AW), .NOTE_W(NW), .TEMPO_W(TW),
    .TEMPO_DEFAULT(TDEF), .GAP_CYCLES(GAPC), .LAST_ADDR(LAST)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pause(pause), .loop_en(loop_en), .tempo_load(tempo_load),
    .tempo_in(tempo_in), .rom_addr(rom_addr), .rom_note(rom_note),
    .note(note), .gate(gate), .busy(busy), .beat(beat),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  function automatic int song(int a);
    case (a % 4)
      0: return 25;
      1: return 0;
      2: return 30;
      default: return 27;
    endcase
  endfunction

  always_ff @(posedge clk) rom_note <= NW'(song(int'(rom_addr)));

  function automatic int play_len(int t);
    return (t > GAPC) ? t - GAPC : 1;
  endfunction

  function automatic int slot_len(int t);
    return 2 + play_len(t) + GAPC + 1;
  endfunction

  function automatic int slot_gate(int a, int t);
    return (song(a) != 0) ? play_len(t) : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    loop_en = 1'b0; tempo_load = 1'b0; tempo_in = '0;
    tempo_m = TDEF;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic load_tempo(input int t);
    tempo_load = 1'b1;
    tempo_in = TW'(t);
    step();
    tempo_load = 1'b0;
    tempo_m = (t == 0) ? 1 : t;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps to the next beat; g counts gate-high cycles from the current
  // cycle up to (not including) the beat cycle.
  task automatic run_to_beat(input int maxc, input int ld_at,
                             input int ld_val, output int n,
                             output int g, output int d,
                             output bit seen);
    n = 0; d = 0; seen = 1'b0;
    g = int'(gate);
    while (n < maxc && !seen) begin
      tempo_load = (n == ld_at);
      if (n == ld_at) tempo_in = TW'(ld_val);
      step();
      n++;
      if (beat) seen = 1'b1;
      else begin
        g += int'(gate);
        d += int'(song_done);
      end
    end
    tempo_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    loop_en = 1'b0; tempo_load = 1'b0; tempo_in = '0;
    #2;
    checks++;
    if ({rom_addr, note} !== '0) begin
      failures++;
      $display("FAIL reset_addr_note: addr=%0d note=%0d want 0 0",
               rom_addr, note);
    end
    checks++;
    if ({gate, busy, beat, song_done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags: g/b/bt/d=%b want 0000",
               {gate, busy, beat, song_done});
    end
    do_reset();
  endtask

  task automatic test_first_slot();
    logic [AW+1:0] got, exp;
    int pl;
    do_reset();
    kick();
    checks++;
    if (rom_addr !== '0 || busy !== 1'b1 || gate !== 1'b0) begin
      failures++;
      $display("FAIL first_c0: addr=%0d busy=%b gate=%b want 0 1 0",
               rom_addr, busy, gate);
    end
    pl = play_len(tempo_m);
    for (int k = 1; k <= 19; k++) begin
      start = (k == 5);
      step();
      got = {beat, gate, rom_addr};
      exp = {k == 2, (k >= 2) && (k < 2 + pl),
             AW'((k >= slot_len(tempo_m)) ? 1 : 0)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL first_c%0d: beat/gate/addr=%h want %h",
                 k, got, exp);
      end
      if (k == 2) begin
        checks++;
        if (note !== NW'(25)) begin
          failures++;
          $display("FAIL first_note: note=%0d want 25", note);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_full_song();
    int n, g, d, t, pb;
    bit seen;
    do_reset();
    t = $urandom_range(5, 24);
    load_tempo(t);
    kick();
    run_to_beat(40, -1, 0, n, g, d, seen);
    checks++;
    if (!seen || n != 2 || note !== NW'(song(0))) begin
      failures++;
      $display("FAIL song_beat0: seen=%0d n=%0d note=%0d want 1 2 %0d",
               seen, n, note, song(0));
    end
    for (int i = 0; i < LAST; i++) begin
      run_to_beat(80, -1, 0, n, g, d, seen);
      checks++;
      if (!seen || n != slot_len(tempo_m) || g != slot_gate(i, tempo_m)
          || d != 0 || note !== NW'(song(i + 1))
          || rom_addr !== AW'(i + 1)) begin
        failures++;
        $display("FAIL song_slot%0d: n=%0d g=%0d d=%0d note=%0d addr=%0d want n=%0d g=%0d d=0 note=%0d addr=%0d",
                 i, n, g, d, note, rom_addr, slot_len(tempo_m),
                 slot_gate(i, tempo_m), song(i + 1), i + 1);
      end
    end
    n = 0; g = int'(gate); pb = 1;
    while (n < 80 && !song_done) begin
      pb = int'(busy);
      step();
      n++;
      if (!song_done) g += int'(gate);
    end
    checks++;
    if (!song_done || n != slot_len(tempo_m) - 2 || pb != 1
        || busy !== 1'b0 || rom_addr !== '0 || note !== '0
        || g != slot_gate(3, tempo_m)) begin
      failures++;
      $display("FAIL song_done: done=%b n=%0d busy=%b/%0d addr=%0d note=%0d g=%0d want 1 %0d 0/1 0 0 %0d",
               song_done, n, busy, pb, rom_addr, note, g,
               slot_len(tempo_m) - 2, slot_gate(3, tempo_m));
    end
    d = 0;
    repeat (25) begin
      step();
      d += int'(song_done) + int'(busy) + int'(gate);
    end
    checks++;
    if (d != 0) begin
      failures++;
      $display("FAIL song_after: activity=%0d want 0", d);
    end
  endtask

  task automatic test_loop();
    int n, g, d;
    bit seen;
    do_reset();
    load_tempo($urandom_range(3, 20));
    loop_en = 1'b1;
    kick();
    run_to_beat(40, -1, 0, n, g, d, seen);
    for (int i = 0; i < 8; i++) begin
      run_to_beat(80, -1, 0, n, g, d, seen);
      checks++;
      if (!seen || n != slot_len(tempo_m) || d != 0 || busy !== 1'b1
          || note !== NW'(song(i + 1))
          || rom_addr !== AW'((i + 1) % 4)) begin
        failures++;
        $display("FAIL loop_slot%0d: n=%0d d=%0d busy=%b note=%0d addr=%0d want n=%0d d=0 busy=1 note=%0d addr=%0d",
                 i, n, d, busy, note, rom_addr, slot_len(tempo_m),
                 song(i + 1), (i + 1) % 4);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int n, g, d, gh, idx, len;
    bit seen, bad;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      kick();
      run_to_beat(40, -1, 0, n, g, d, seen);
      idx = (it == 0) ? 4 : $urandom_range(0, 11);
      len = (it == 0) ? 10 : $urandom_range(1, 12);
      gh = int'(gate);
      repeat (idx) begin
        step();
        gh += int'(gate);
      end
      pause = 1'b1;
      bad = 1'b0;
      for (int j = 0; j < len; j++) begin
        step();
        if (gate !== 1'b0 || rom_addr !== '0 || busy !== 1'b1
            || beat !== 1'b0) bad = 1'b1;
      end
      pause = 1'b0;
      checks++;
      if (bad || gh != idx + 1) begin
        failures++;
        $display("FAIL pause_hold%0d: bad=%0d gh=%0d want 0 %0d",
                 it, bad, gh, idx + 1);
      end
      run_to_beat(80, -1, 0, n, g, d, seen);
      checks++;
      if (!seen || g != play_len(tempo_m) - (idx + 1)
          || idx + len + n != slot_len(tempo_m) + len
          || rom_addr !== AW'(1)) begin
        failures++;
        $display("FAIL pause_resume%0d: g=%0d slot=%0d addr=%0d want %0d %0d 1",
                 it, g, idx + len + n, rom_addr,
                 play_len(tempo_m) - (idx + 1), slot_len(tempo_m) + len);
      end
    end
  endtask

  task automatic test_tempo();
    int n, g, d, t;
    bit seen;
    int tl[4];
    tl = '{8, 2, 0, $urandom_range(3, 30)};
    for (int it = 0; it < 4; it++) begin
      do_reset();
      kick();
      run_to_beat(40, -1, 0, n, g, d, seen);
      t = tl[it];
      run_to_beat(80, 3, t, n, g, d, seen);
      checks++;
      if (!seen || n != slot_len(TDEF) || g != play_len(TDEF)) begin
        failures++;
        $display("FAIL tempo_keep%0d: n=%0d g=%0d want %0d %0d",
                 it, n, g, slot_len(TDEF), play_len(TDEF));
      end
      tempo_m = (t == 0) ? 1 : t;
      run_to_beat(80, -1, 0, n, g, d, seen);
      checks++;
      if (!seen || n != slot_len(tempo_m) || g != 0) begin
        failures++;
        $display("FAIL tempo_rest%0d: n=%0d g=%0d want %0d 0",
                 it, n, g, slot_len(tempo_m));
      end
      run_to_beat(80, -1, 0, n, g, d, seen);
      checks++;
      if (!seen || n != slot_len(tempo_m) || g != play_len(tempo_m)) begin
        failures++;
        $display("FAIL tempo_new%0d: n=%0d g=%0d want %0d %0d",
                 it, n, g, slot_len(tempo_m), play_len(tempo_m));
      end
    end
  endtask

  task automatic test_stop_gap();
    int n, g, d, off, act;
    bit seen;
    do_reset();
    kick();
    repeat (3) run_to_beat(80, -1, 0, n, g, d, seen);
    off = $urandom_range(12, 15);
    repeat (off) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || note !== '0 || rom_addr !== '0
        || gate !== 1'b0 || song_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_gap: busy=%b note=%0d addr=%0d gate=%b done=%b want 0 0 0 0 0",
               busy, note, rom_addr, gate, song_done);
    end
    act = 0;
    repeat (20) begin
      step();
      act += int'(song_done) + int'(busy) + int'(beat);
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL stop_after: activity=%0d want 0", act);
    end
  endtask

  task automatic test_start_stop();
    int act;
    do_reset();
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    act = 0;
    pause = 1'b1;
    repeat (6) begin
      act += int'(busy) + int'(beat);
      step();
    end
    pause = 1'b0;
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL start_stop_idle: activity=%0d want 0", act);
    end
  endtask

  task automatic test_start_pause();
    int n, g, d, k;
    bit seen, bad;
    do_reset();
    pause = 1'b1;
    kick();
    bad = (busy !== 1'b1) || (gate !== 1'b0);
    k = $urandom_range(1, 6);
    repeat (k) begin
      step();
      if (busy !== 1'b1 || beat !== 1'b0 || gate !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL start_paused: bad=1 want 0");
    end
    pause = 1'b0;
    run_to_beat(20, -1, 0, n, g, d, seen);
    checks++;
    if (!seen || n != 3 || note !== NW'(25)) begin
      failures++;
      $display("FAIL start_resume: seen=%0d n=%0d note=%0d want 1 3 25",
               seen, n, note);
    end
  endtask

  task automatic test_rst_mid_play();
    int n, g, d;
    bit seen;
    do_reset();
    kick();
    run_to_beat(40, -1, 0, n, g, d, seen);
    repeat (3) step();
    checks++;
    if (gate !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: gate=%b want 1", gate);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (gate !== 1'b0 || busy !== 1'b0 || note !== '0
        || rom_addr !== '0) begin
      failures++;
      $display("FAIL rst_async: gate=%b busy=%b note=%0d addr=%0d want 0 0 0 0",
               gate, busy, note, rom_addr);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_slot();
    test_full_song();
    test_loop();
    test_pause();
    test_tempo();
    test_stop_gap();
    test_start_stop();
    test_start_pause();
    test_rst_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
